// File: rtl/core_inst_seq_if.sv
// Control/status bundle between the pass controller and the sequencer.
// Also carries the core status flags and the issued instruction word.
interface core_inst_seq_if #(
  parameter int AW = 11
);
  logic          start;
  logic [AW-1:0] w_base;
  logic [AW-1:0] x_base;
  logic [AW-1:0] p_base;
  logic          l0_full;
  logic          ofifo_valid;
  logic [33:0]   inst;
  logic          busy;
  logic          done;
  logic [3:0]    kij_idx;
  logic          err;

  modport master (
    output start, w_base, x_base, p_base,
    output l0_full, ofifo_valid,
    input  inst, busy, done, kij_idx, err
  );

  modport slave (
    input  start, w_base, x_base, p_base,
    input  l0_full, ofifo_valid,
    output inst, busy, done, kij_idx, err
  );
endinterface

// File: rtl/core_inst_seq.sv
// Instruction sequencer for the multi-corelet core: per kij it issues
// weight fetch/load, activation fetch, execute and OFIFO drain words.
module core_inst_seq #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int KIJ_NUM  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LOAD_GAP = 16,
  parameter int AW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  core_inst_seq_if.slave bus
);
  localparam int CW =
    $clog2(ROW + COL + LEN_NIJ + LOAD_GAP + 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WF   = 3'd1;
  localparam logic [2:0] S_WL   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_XF   = 3'd4;
  localparam logic [2:0] S_EX   = 3'd5;
  localparam logic [2:0] S_DR   = 3'd6;
  localparam logic [2:0] S_DN   = 3'd7;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic [2:0]    r_state;
  logic [2:0]    w_nstate;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_kij;
  logic [AW-1:0] r_wb;
  logic [AW-1:0] r_xb;
  logic [AW-1:0] r_pb;
  logic [33:0]   r_inst;
  logic [33:0]   w_inst;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_step;
  logic          w_kinc;
  logic          w_last_kij;
  logic [AW-1:0] w_cnt_a;
  logic [AW-1:0] w_wa;
  logic [AW-1:0] w_xa;

  assign w_cnt_a    = AW'(r_cnt);
  assign w_wa       = r_wb + AW'(r_kij) * AW'(COL) + w_cnt_a;
  assign w_xa       = r_xb + AW'(r_kij) * AW'(LEN_NIJ) + w_cnt_a;
  assign w_last_kij = (r_kij == 4'(KIJ_NUM - 1));

  always_comb begin
    w_nstate = r_state;
    w_inst   = IDLE_W;
    w_step   = 1'b0;
    w_kinc   = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (bus.start) w_nstate = S_WF;
      end
      (r_state == S_WF): begin
        w_step = 1'b1;
        if (r_cnt < CW'(COL)) begin
          w_inst[19]       = 1'b0;
          w_inst[7 +: AW]  = w_wa;
        end
        w_inst[2] = (r_cnt != '0);
        if (r_cnt == CW'(COL)) w_nstate = S_WL;
      end
      (r_state == S_WL): begin
        w_step    = 1'b1;
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
        if (r_cnt == CW'(COL - 1)) w_nstate = S_GAP;
      end
      (r_state == S_GAP): begin
        w_step = 1'b1;
        if (r_cnt == CW'(LOAD_GAP - 1)) w_nstate = S_XF;
      end
      (r_state == S_XF): begin
        w_step = 1'b1;
        if (r_cnt < CW'(LEN_NIJ)) begin
          w_inst[19]       = 1'b0;
          w_inst[7 +: AW]  = w_xa;
        end
        w_inst[2] = (r_cnt != '0);
        if (r_cnt == CW'(LEN_NIJ)) w_nstate = S_EX;
      end
      (r_state == S_EX): begin
        w_step    = 1'b1;
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
        if (r_cnt == CW'(LEN_NIJ - 1)) w_nstate = S_DR;
      end
      (r_state == S_DR): begin
        // cnt counts completed reads, so it holds while the OFIFO is empty
        if (bus.ofifo_valid) begin
          w_step           = 1'b1;
          w_inst[33]       = (r_kij != 4'd0);
          w_inst[32]       = 1'b0;
          w_inst[31]       = 1'b0;
          w_inst[20 +: AW] = r_pb + w_cnt_a;
          w_inst[6]        = 1'b1;
          if (r_cnt == CW'(LEN_NIJ - 1)) begin
            if (w_last_kij) begin
              w_nstate = S_DN;
            end else begin
              w_nstate = S_WF;
              w_kinc   = 1'b1;
            end
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kij   <= 4'd0;
      r_wb    <= '0;
      r_xb    <= '0;
      r_pb    <= '0;
      r_inst  <= IDLE_W;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_inst  <= w_inst;
      r_done  <= (r_state == S_DN);
      r_err   <= r_err | (r_inst[2] & bus.l0_full);
      if (w_nstate != r_state) r_cnt <= '0;
      else if (w_step)         r_cnt <= r_cnt + CW'(1);
      if (r_state == S_IDLE && bus.start) begin
        r_wb   <= bus.w_base;
        r_xb   <= bus.x_base;
        r_pb   <= bus.p_base;
        r_kij  <= 4'd0;
        r_busy <= 1'b1;
      end
      if (w_kinc) r_kij <= r_kij + 4'd1;
      if (r_state == S_DN) r_busy <= 1'b0;
    end
  end

  assign bus.inst    = r_inst;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.kij_idx = r_kij;
  assign bus.err     = r_err;
endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
Instruction sequencer that drives the 34-bit `inst` bus of the multi-corelet core. It replaces the testbench-driven instruction stream.
For each kernel index kij it issues, in order: weight fetch into L0, weight load into the PEs, activation fetch into L0, execute, and OFIFO drain into psum SRAM.
It sits between the top-level controller/testbench and `core`. It observes the core's L0/OFIFO status flags and emits exactly one instruction word per cycle.

Parameters:
row, 8, PE array rows
col, 8, PE array columns; number of weight words per kij
kij_num, 9, kernel positions per tile pass
len_nij, 36, activation words per kij; also the number of psum words drained per kij
load_gap, 16, idle cycles after weight load before activation fetch (array settle, row+col)
aw, 11, SRAM address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset=0 resets)
start  in  1  one-cycle request to begin a tile pass; ignored while busy
w_base  in  aw  xmem base address of weights
x_base  in  aw  xmem base address of activations
p_base  in  aw  pmem base address of psums
l0_full  in  1  core L0 full flag
ofifo_valid  in  1  core OFIFO has a full output row
inst  out  34  instruction to core, registered
busy  out  1  pass in progress
done  out  1  one-cycle pulse when the pass completes
kij_idx  out  4  current kij
err  out  1  sticky: l0_wr issued while l0_full=1

Behaviour:
- Instruction field layout:
  - acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20]
  - CEN_xmem[19], WEN_xmem[18], A_xmem[17:7]
  - ofifo_rd[6], bits[5:4]=0, l0_rd[3], l0_wr[2], execute[1], load[0]
  - CEN/WEN are active-low.
- IDLE word: CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1; all other bits 0. This is `inst` at reset and in every cycle not specified below.
- Reset (async, any state): state=IDLE, inst=IDLE word, busy=0, done=0, kij_idx=0, err=0, all counters 0. A reset mid-pass abandons the pass; no done pulse follows.
- All outputs are registered. The state change and the inst word take effect on the clock edge after the decision.
- One cycle counter `cnt` is cleared on every state entry.
- States:
  - IDLE: on start=1, capture the three bases, set kij=0 and busy=1, go to W_FETCH.
  - W_FETCH (col+1 cycles):
    - cnt<col: xmem read, CEN_xmem=0, WEN_xmem=1, A_xmem = w_base + kij*col + cnt.
    - cnt>=1: l0_wr=1, accounting for the 1-cycle SRAM read latency.
    - Read and l0_wr overlap in the same word. Go to W_LOAD.
  - W_LOAD (col cycles): l0_rd=1, load=1. Go to GAP.
  - GAP (load_gap cycles): IDLE word. Go to X_FETCH.
  - X_FETCH (len_nij+1 cycles): same pattern as W_FETCH, with A_xmem = x_base + kij*len_nij + cnt. Go to EXEC.
  - EXEC (len_nij cycles): l0_rd=1, execute=1. Go to DRAIN.
  - DRAIN:
    - Each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = p_base + cnt, acc = (kij!=0); cnt increments.
    - Cycles with ofifo_valid=0: IDLE word; cnt holds.
    - After len_nij reads: if kij==kij_num-1, go to DONE; else kij++ and go to W_FETCH.
  - DONE (1 cycle): done=1, busy=0, go to IDLE.
- busy=1 from the cycle after start is accepted through the last DRAIN cycle.
- kij_idx reflects kij.
- Address arithmetic is modulo 2^aw; wrap-around is silent.
- err: set when an issued inst has l0_wr=1 and l0_full=1 in that cycle. No stall is performed, because legal configs keep each phase at or below the L0 depth. Cleared only by reset.
- start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.

Test Plan:
- Reset, then idle: reset=0 for 3 cycles, release, no start → inst = 34'h1_800C_0000 constant (bits 32,31,19,18 set); busy=0, done=0, err=0.
- Single kij pass (kij_num=1, col=8, len_nij=4, load_gap=2, w_base=0x10, x_base=0x40, p_base=0x100, ofifo_valid tied 1):
  - xmem reads at 0x10..0x17, then 8 load cycles, then 2 idle cycles, then reads at 0x40..0x43, then 4 execute cycles.
  - pmem writes at 0x100..0x103 with acc=0.
  - done pulses exactly at cycle 1+9+8+2+5+4+4+1 after start.
- Multi-kij accumulate (kij_num=3): second pass weight reads start at w_base+8, activation reads at x_base+2*len_nij in the third pass; acc=0 on kij 0 and acc=1 on kij 1 and 2; kij_idx steps 0,1,2.
- OFIFO backpressure: in DRAIN, toggle ofifo_valid 1,0,0,1,… → ofifo_rd/pmem write only in valid cycles, A_pmem increments only on reads, total reads = len_nij.
- Reset mid-EXEC: assert reset during EXEC → inst = IDLE word immediately (async), busy=0, no done pulse; a new start runs a clean pass from kij 0.
- Error flag and start-while-busy: hold l0_full=1 during X_FETCH → err=1 and stays 1 after done. Pulse start mid-pass → no effect on sequence or counts.
